bcd_timer_ctrl: RTL
===================

BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50, clk cycles per count step (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1, level sampled each cycle: begin or resume counting.
REQ-005 SHALL have port stop, input, 1, pause when RUN; abort to IDLE when PAUSE.
REQ-006 SHALL have port clear, input, 1, synchronous return to IDLE with count 00.
REQ-007 SHALL have port load, input, 1, load preset digits into count.
REQ-008 SHALL have port preset1 / preset0, input, 4 each, BCD tens / ones preset.
REQ-009 SHALL have port dir, input, 1, direction: 0 = up, 1 = down.
REQ-010 SHALL have port q1 / q0, output, 4 each, BCD tens / ones of current count.
REQ-011 SHALL have port state, output, 2, FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-012 SHALL have port busy, output, 1, high while state is RUN or PAUSE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on entry to DONE.

Function
REQ-014 SHALL store the count as two BCD digits; q0 and q1 SHALL each stay in 0..9 at all times.
REQ-015 SHALL clock all registers on clk only; digits SHALL NOT be clocked from carry signals.
REQ-016 SHALL resolve same-cycle commands in this priority: clear > load > stop > start.
REQ-017 IDLE: start -> RUN, latch dir into internal dir_r, prescaler = 0; load -> count = preset, stay IDLE.
REQ-018 IDLE start with count already at terminal (99 if dir=1'b0, 00 if dir=1'b1) -> DONE next cycle, done pulse, count unchanged.
REQ-019 RUN: prescaler counts 0..TICK_DIV-1; a step occurs in the cycle prescaler = TICK_DIV-1, then prescaler wraps to 0.
REQ-020 First count step SHALL be visible on q TICK_DIV cycles after the start-accepting edge.
REQ-021 Up step: ones 9 -> 0 with tens +1; otherwise ones +1.
REQ-022 Down step: ones 0 -> 9 with tens -1; otherwise ones -1.
REQ-023 A step producing 99 (up) or 00 (down) SHALL move FSM to DONE on the same edge; done SHALL pulse the following cycle only.
REQ-024 dir changes during RUN/PAUSE SHALL be ignored; dir_r governs until the next IDLE start.
REQ-025 RUN: stop -> PAUSE; prescaler and count SHALL be frozen.
REQ-026 PAUSE: start -> RUN, resuming from the frozen prescaler value; stop -> IDLE, count retained.
REQ-027 load SHALL be ignored in RUN and PAUSE.
REQ-028 DONE: hold count; start and stop ignored; load -> count = preset, IDLE; clear -> IDLE, 00.
REQ-029 A preset digit > 9 SHALL load as 9.
REQ-030 clear in any state -> IDLE, q1 = q0 = 0, prescaler = 0, done = 0 next cycle.

Reset
REQ-031 reset high SHALL immediately force state = IDLE, q1 = q0 = 0, prescaler = 0, dir_r = 0, done = 0, busy = 0.
REQ-032 reset asserted mid-RUN SHALL abort with no done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-033 TICK_DIV=4, reset, start dir=0 -> q0 reaches 1 four cycles after start, 99 after 396 cycles; DONE entered; done pulses once.
REQ-034 load preset 0x12, start dir=1, TICK_DIV=1 -> sequence 11,10,09,...,01,00; DONE at 00; q1 borrows correctly at 10 -> 09.
REQ-035 RUN, stop for 10 cycles, start -> count frozen for those 10 cycles; step timing resumes from the held prescaler value; then stop twice -> IDLE, count retained.
REQ-036 Same-cycle clear+load+start -> IDLE, 00; same-cycle load+start in IDLE -> preset loaded, still IDLE; preset 0xAF -> count 99.
REQ-037 Count 99, dir=0, start -> DONE next cycle, single done pulse, q unchanged; start held in DONE -> no further pulse.
REQ-038 reset asserted asynchronously mid-RUN at count 47 -> outputs 00 / IDLE before the next clk edge; no done pulse.

Source files
------------

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl
// Two-digit BCD up/down timer with a start/stop/pause/done control FSM.
// A prescaler divides clk by TICK_DIV to produce count steps. All state,
// including the BCD digits, is clocked by clk; carries and borrows are
// resolved combinationally within a single step.
module bcd_timer_ctrl #(
    parameter int TICK_DIV = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] preset1,
    input  logic [3:0] preset0,
    input  logic       dir,
    output logic [3:0] q1,
    output logic [3:0] q0,
    output logic [1:0] state,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    // Last prescaler value; the step fires in the cycle the prescaler holds it.
    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    // Presets above 9 are not BCD; saturate them to 9.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // One BCD increment of {tens, ones}; wraps 99 -> 00 so digits stay legal.
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] o);
        logic [3:0] t_n;
        logic [3:0] o_n;
        if (o >= 4'd9) begin
            o_n = 4'd0;
            t_n = (t >= 4'd9) ? 4'd0 : t + 4'd1;
        end else begin
            o_n = o + 4'd1;
            t_n = t;
        end
        return {t_n, o_n};
    endfunction

    // One BCD decrement of {tens, ones}; wraps 00 -> 99 so digits stay legal.
    function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
        logic [3:0] t_n;
        logic [3:0] o_n;
        if (o == 4'd0) begin
            o_n = 4'd9;
            t_n = (t == 4'd0) ? 4'd9 : t - 4'd1;
        end else begin
            o_n = o - 4'd1;
            t_n = t;
        end
        return {t_n, o_n};
    endfunction

    state_t      state_r, state_n;
    logic [3:0]  q1_r, q1_n;
    logic [3:0]  q0_r, q0_n;
    logic [15:0] presc_r, presc_n;
    logic        dir_r, dir_n;
    logic        done_r, done_n;

    logic [7:0]  count;
    logic [7:0]  step_val;
    logic        step_term;
    logic        start_term;
    logic        tick;

    assign count      = {q1_r, q0_r};
    // Step result and terminal test use the latched direction, so dir
    // wiggling while running or paused has no effect.
    assign step_val   = dir_r ? bcd_dec(q1_r, q0_r) : bcd_inc(q1_r, q0_r);
    assign step_term  = dir_r ? (step_val == 8'h00) : (step_val == 8'h99);
    // Starting from IDLE checks the live dir, since that is what gets latched.
    assign start_term = dir ? (count == 8'h00) : (count == 8'h99);
    assign tick       = (presc_r == TICK_LAST);

    // Next-state logic: command priority is clear > load > stop > start.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_n = state_r;
        q1_n    = q1_r;
        q0_n    = q0_r;
        presc_n = presc_r;
        dir_n   = dir_r;

        if (clear) begin
            state_n = IDLE;
            q1_n    = 4'd0;
            q0_n    = 4'd0;
            presc_n = 16'd0;
        end else begin
            unique case (state_r)
                IDLE: begin
                    if (load) begin
                        q1_n = clamp_digit(preset1);
                        q0_n = clamp_digit(preset0);
                    end else if (stop) begin
                        // stop outranks start; nothing to pause in IDLE
                        state_n = IDLE;
                    end else if (start) begin
                        dir_n   = dir;
                        presc_n = 16'd0;
                        state_n = start_term ? DONE : RUN;
                    end
                end
                RUN: begin
                    // load is ignored while running
                    if (stop) begin
                        state_n = PAUSE;
                    end else if (tick) begin
                        presc_n = 16'd0;
                        q1_n    = step_val[7:4];
                        q0_n    = step_val[3:0];
                        if (step_term) begin
                            state_n = DONE;
                        end
                    end else begin
                        presc_n = presc_r + 16'd1;
                    end
                end
                PAUSE: begin
                    // Prescaler stays frozen so a resume continues mid-period.
                    if (stop) begin
                        state_n = IDLE;
                        presc_n = 16'd0;
                    end else if (start) begin
                        state_n = RUN;
                    end
                end
                DONE: begin
                    if (load) begin
                        q1_n    = clamp_digit(preset1);
                        q0_n    = clamp_digit(preset0);
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // The pulse is registered, so it is high exactly for the first DONE cycle.
        done_n = (state_n == DONE) && (state_r != DONE);
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            q1_r    <= 4'd0;
            q0_r    <= 4'd0;
            presc_r <= 16'd0;
            dir_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            state_r <= state_n;
            q1_r    <= q1_n;
            q0_r    <= q0_n;
            presc_r <= presc_n;
            dir_r   <= dir_n;
            done_r  <= done_n;
        end
    end

    assign q1    = q1_r;
    assign q0    = q0_r;
    assign state = state_r;
    assign busy  = (state_r == RUN) || (state_r == PAUSE);
    assign done  = done_r;

endmodule
